seq_pattern_detector: RTL and testbench

- Parametrised serial bit-pattern detector; successor to the fixed 5-bit Mealy detector.
- Pattern value, don't-care mask and overlap mode are runtime-loadable. Input is valid-qualified.
- Keeps a saturating match counter.
- Sits on a serial input stream and flags each occurrence of the programmed sequence, one bit per valid cycle.

---
 rtl/seq_pattern_detector.sv | 139 +++++++++++++
 tb/tb_seq_pattern_detector.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_detector.sv
// Serial bit-pattern detector with runtime-loadable pattern, don't-care mask and
// overlap mode, valid-qualified input and a saturating match counter.
module seq_pattern_detector #(
  parameter int                 PAT_LEN         = 5,
  parameter logic [PAT_LEN-1:0] DEFAULT_PATTERN = 5'b00110,
  parameter logic [PAT_LEN-1:0] DEFAULT_MASK    = '1,
  parameter logic               DEFAULT_OVERLAP = 1'b1,
  parameter int                 CNT_W           = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic               in,
  input  logic               cfg_load,
  input  logic [PAT_LEN-1:0] cfg_pattern,
  input  logic [PAT_LEN-1:0] cfg_mask,
  input  logic               cfg_overlap,
  input  logic               clr_count,
  output logic               found,
  output logic [CNT_W-1:0]   match_count,
  output logic               count_sat,
  output logic               armed
);

  localparam int               FW      = $clog2(PAT_LEN + 1);
  localparam logic [FW-1:0]    FULL    = FW'(PAT_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_ARMED = 1'b1
  } state_t;

  state_t             state_r, state_next_s;
  logic [PAT_LEN-1:0] history_r, history_next_s, history_shift_s;
  logic [FW-1:0]      fill_r, fill_next_s, fill_inc_s;
  logic [PAT_LEN-1:0] pattern_r, pattern_next_s;
  logic [PAT_LEN-1:0] mask_r, mask_next_s;
  logic               overlap_r, overlap_next_s;
  logic               found_r, match_s;
  logic [CNT_W-1:0]   count_r, count_next_s;
  logic               sat_r, sat_next_s;
  logic               armed_r;

  // Next-state, match decode and counter update.
  always_comb begin
    history_shift_s = {history_r[PAT_LEN-2:0], in};
    if (fill_r == FULL) begin
      fill_inc_s = FULL;
    end else begin
      fill_inc_s = fill_r + FW'(1);
    end

    if (!cfg_load && in_valid && (fill_inc_s == FULL) &&
        (((history_shift_s ^ pattern_r) & mask_r) == {PAT_LEN{1'b0}})) begin
      match_s = 1'b1;
    end else begin
      match_s = 1'b0;
    end

    state_next_s   = state_r;
    history_next_s = history_r;
    fill_next_s    = fill_r;
    pattern_next_s = pattern_r;
    mask_next_s    = mask_r;
    overlap_next_s = overlap_r;

    if (cfg_load) begin
      pattern_next_s = cfg_pattern;
      mask_next_s    = cfg_mask;
      overlap_next_s = cfg_overlap;
      history_next_s = {PAT_LEN{1'b0}};
      fill_next_s    = {FW{1'b0}};
      state_next_s   = ST_FILL;
    end else if (in_valid) begin
      // A non-overlapping match consumes the whole window.
      if (match_s && !overlap_r) begin
        history_next_s = {PAT_LEN{1'b0}};
        fill_next_s    = {FW{1'b0}};
        state_next_s   = ST_FILL;
      end else begin
        history_next_s = history_shift_s;
        fill_next_s    = fill_inc_s;
        case (state_r)
          ST_FILL:  state_next_s = (fill_inc_s == FULL) ? ST_ARMED : ST_FILL;
          ST_ARMED: state_next_s = ST_ARMED;
          default:  state_next_s = ST_FILL;
        endcase
      end
    end else begin
      state_next_s = state_r;
    end

    count_next_s = count_r;
    sat_next_s   = sat_r;
    if (clr_count) begin
      count_next_s = {CNT_W{1'b0}};
      sat_next_s   = 1'b0;
    end else if (match_s && (count_r != CNT_MAX)) begin
      count_next_s = count_r + CNT_W'(1);
      sat_next_s   = ((count_r + CNT_W'(1)) == CNT_MAX) ? 1'b1 : sat_r;
    end else begin
      count_next_s = count_r;
    end
  end

  // State, configuration and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_FILL;
      history_r <= {PAT_LEN{1'b0}};
      fill_r    <= {FW{1'b0}};
      pattern_r <= DEFAULT_PATTERN;
      mask_r    <= DEFAULT_MASK;
      overlap_r <= DEFAULT_OVERLAP;
      found_r   <= 1'b0;
      count_r   <= {CNT_W{1'b0}};
      sat_r     <= 1'b0;
      armed_r   <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      history_r <= history_next_s;
      fill_r    <= fill_next_s;
      pattern_r <= pattern_next_s;
      mask_r    <= mask_next_s;
      overlap_r <= overlap_next_s;
      found_r   <= match_s;
      count_r   <= count_next_s;
      sat_r     <= sat_next_s;
      armed_r   <= (state_next_s == ST_ARMED);
    end
  end

  assign found       = found_r;
  assign match_count = count_r;
  assign count_sat   = sat_r;
  assign armed       = armed_r;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Scoreboard bench for seq_pattern_detector: a queue-based reference model predicts
// each cycle's outputs, and a negedge monitor pops and compares them.
module tb_seq_pattern_detector;

  localparam int PL    = 5;
  localparam int CW    = 3;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          din = 1'b0;
  logic          cfg_load = 1'b0;
  logic [PL-1:0] cfg_pattern = 5'b00000;
  logic [PL-1:0] cfg_mask = 5'b00000;
  logic          cfg_overlap = 1'b0;
  logic          clr_count = 1'b0;
  logic          found;
  logic [CW-1:0] match_count;
  logic          count_sat;
  logic          armed;

  seq_pattern_detector #(.PAT_LEN(PL), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in(din),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask),
    .cfg_overlap(cfg_overlap), .clr_count(clr_count),
    .found(found), .match_count(match_count), .count_sat(count_sat), .armed(armed)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit found;
    int cnt;
    bit sat;
    bit armed;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   found_seen = 0;
  int   cyc = 0;

  // Reference model: list of valid bits since the last restart.
  bit      hq[$];
  bit [PL-1:0] m_pat = 5'b00110;
  bit [PL-1:0] m_mask = 5'b11111;
  bit      m_ov = 1'b1;
  int      m_cnt = 0;
  bit      m_sat = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    hq.delete();
    m_pat = 5'b00110; m_mask = 5'b11111; m_ov = 1'b1;
    m_cnt = 0; m_sat = 1'b0;
  endtask

  function automatic exp_t model_step(input bit v, input bit b, input bit ld,
                                      input bit [PL-1:0] p, input bit [PL-1:0] mk,
                                      input bit ov, input bit clr);
    exp_t e;
    bit hit;
    e.found = 1'b0;
    if (ld) begin
      m_pat = p; m_mask = mk; m_ov = ov;
      hq.delete();
    end else if (v) begin
      hq.push_back(b);
      if (hq.size() > PL) void'(hq.pop_front());
      if (hq.size() == PL) begin
        hit = 1'b1;
        for (int i = 0; i < PL; i++)
          if (m_mask[PL-1-i] && (hq[i] != m_pat[PL-1-i])) hit = 1'b0;
        if (hit) begin
          e.found = 1'b1;
          if (!m_ov) hq.delete();
        end
      end
    end
    if (clr) begin
      m_cnt = 0; m_sat = 1'b0;
    end else if (e.found && m_cnt < CMAX) begin
      m_cnt++;
      if (m_cnt == CMAX) m_sat = 1'b1;
    end
    e.cnt = m_cnt; e.sat = m_sat; e.armed = (hq.size() == PL);
    return e;
  endfunction

  task automatic step(input bit v, input bit b, input bit ld, input bit clr);
    exp_t e;
    #1;
    in_valid = v; din = b; cfg_load = ld; clr_count = clr;
    @(posedge clk);
    e = model_step(v, b, ld, cfg_pattern, cfg_mask, cfg_overlap, clr);
    q.push_back(e);
    cyc++;
  endtask

  task automatic load(input bit [PL-1:0] p, input bit [PL-1:0] mk, input bit ov);
    cfg_pattern = p; cfg_mask = mk; cfg_overlap = ov;
    step(1'b1, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic run_stream(input string s);
    for (int i = 0; i < s.len(); i++) step(1'b1, s[i] == "1", 1'b0, 1'b0);
  endtask

  // Monitor: pops one expected record per driven cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("found", found, e.found);
        check("match_count", match_count, e.cnt);
        check("count_sat", count_sat, e.sat);
        check("armed", armed, e.armed);
        if (found) found_seen++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    string s1 = "1001100110101100110";
    #1;
    check("reset_found", found, 0);
    check("reset_count", match_count, 0);
    check("reset_armed", armed, 0);
    check("reset_sat", count_sat, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Defaults, overlapping: pulses after bits 5, 9, 18.
    f0 = found_seen;
    run_stream(s1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("t1_pulses", found_seen - f0, 3);
    check("t1_count", match_count, 3);

    // Non-overlapping, counter cleared first: pulses after bits 5 and 18.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    load(5'b00110, 5'b11111, 1'b0);
    f0 = found_seen;
    run_stream(s1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("t2_pulses", found_seen - f0, 2);
    check("t2_count", match_count, 2);

    // Masked pattern with gaps inside the window.
    load(5'b00110, 5'b11101, 1'b1);
    f0 = found_seen;
    run_stream("00");
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    run_stream("10");
    step(1'b0, 1'b0, 1'b0, 1'b0);
    run_stream("0");
    step(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("t3_pulses", found_seen - f0, 1);

    // Saturation with an all-don't-care mask, then clears.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    load(5'b00000, 5'b00000, 1'b1);
    for (int i = 0; i < 14; i++) step(1'b1, 1'($urandom_range(1)), 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);

    // cfg_load on the completing bit suppresses the match.
    load(5'b00110, 5'b11111, 1'b1);
    run_stream("0011");
    cfg_pattern = 5'b00110; cfg_mask = 5'b11111; cfg_overlap = 1'b1;
    step(1'b1, 1'b0, 1'b1, 1'b0);
    run_stream("00110");

    // Asynchronous reset while found is high; defaults come back.
    load(5'b10101, 5'b11111, 1'b0);
    run_stream("10101");
    #2;
    check("pre_reset_found", found, 1);
    rst_n = 1'b0;
    q.delete();
    #1;
    check("arst_found", found, 0);
    check("arst_count", match_count, 0);
    check("arst_armed", armed, 0);
    check("arst_sat", count_sat, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    run_stream("1001100110");

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) == 0) begin
        cfg_pattern = PL'($urandom);
        cfg_mask = ($urandom_range(1) == 1) ? PL'($urandom) : 5'b11111;
        cfg_overlap = 1'($urandom_range(1));
        step(1'($urandom_range(1)), 1'($urandom_range(1)), 1'b1, 1'($urandom_range(49) == 0));
      end else begin
        step($urandom_range(9) < 8, 1'($urandom_range(1)), 1'b0, $urandom_range(59) == 0);
      end
    end
    @(negedge clk);
    @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
